// File: rtl/w0rm_dbus_sram_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// w0rm_dbus_sram_responder
//
// Slave end of the W0RM core data port. Every request strobed on bus_valid_i
// is queued in a small FIFO and then serviced in order by a two-state FSM.
// The FSM inserts WAIT_STATES extra cycles and then performs one word access
// on an internal SRAM. Each serviced request produces exactly one
// single-cycle bus_valid_o pulse. The port has no back-pressure, so a request
// that arrives while the FIFO is full (and nothing pops that cycle) is
// dropped and recorded in the sticky overflow_o flag.
//
// Optional feature: define W0RM_DBUS_ADDR_CHECK_EN to make misaligned or
// out-of-range addresses error responses. Without it, the low two address
// bits and the bits above the word index are ignored, so the address wraps
// modulo MEM_WORDS.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-low reset (SRAM contents are kept)
//   bus_addr_i   byte address of the request
//   bus_data_i   write data of the request
//   bus_read_i   read request
//   bus_write_i  write request
//   bus_valid_i  request strobe, sampled on every rising edge
//   bus_data_o   read data; 0 for writes, errors and idle cycles
//   bus_valid_o  response strobe, one cycle per accepted request
//   overflow_o   sticky: a request was dropped
//   err_o        sticky: a bad request was serviced
//   busy_o       FIFO not empty or FSM not idle
// -----------------------------------------------------------------------------
module w0rm_dbus_sram_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    input  logic                  bus_read_i,
    input  logic                  bus_write_i,
    input  logic                  bus_valid_i,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_valid_o,
    output logic                  overflow_o,
    output logic                  err_o,
    output logic                  busy_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Request queue storage
    logic [ADDR_WIDTH-1:0] fifo_addr_r  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r  [FIFO_DEPTH];
    logic                  fifo_read_r  [FIFO_DEPTH];
    logic                  fifo_write_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;

    // Word-wide SRAM
    logic [DATA_WIDTH-1:0] sram_r [MEM_WORDS];

    // Service state
    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADDR_WIDTH-1:0] svc_addr_r;
    logic [DATA_WIDTH-1:0] svc_data_r;
    logic                  svc_read_r;
    logic                  svc_write_r;

    // Output registers
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  overflow_r;
    logic                  err_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  access_s;
    logic                  addr_ok_s;
    logic                  rd_ok_s;
    logic                  we_s;
    logic                  err_s;
    logic [IDX_W-1:0]      idx_s;

    assign full_s  = (count_r == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_s = (count_r == {(PTR_W + 1){1'b0}});
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;
    // A full queue still accepts a request when the head leaves the same cycle.
    assign push_s  = bus_valid_i && (!full_s || pop_s);
    assign drop_s  = bus_valid_i && full_s && !pop_s;

    assign access_s = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}});
    assign idx_s    = svc_addr_r[IDX_W+1:2];

`ifdef W0RM_DBUS_ADDR_CHECK_EN
    assign addr_ok_s = (svc_addr_r[1:0] == 2'b00) &&
                       ((svc_addr_r >> (IDX_W + 2)) == {ADDR_WIDTH{1'b0}});
`else
    assign addr_ok_s = 1'b1;
`endif

    // Exactly one of read/write must be set; anything else is an error access.
    assign rd_ok_s = access_s && svc_read_r && !svc_write_r && addr_ok_s;
    // Reset gates the write so an access aborted by reset never lands.
    assign we_s    = access_s && svc_write_r && !svc_read_r && addr_ok_s && reset;
    assign err_s   = access_s && !((svc_read_r ^ svc_write_r) && addr_ok_s);

    // Queue payload storage; pointers are reset separately so no reset here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r]  <= bus_addr_i;
            fifo_data_r[wr_ptr_r]  <= bus_data_i;
            fifo_read_r[wr_ptr_r]  <= bus_read_i;
            fifo_write_r[wr_ptr_r] <= bus_write_i;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            sram_r[idx_s] <= svc_data_r;
        end
    end

    // Service FSM with registered response and sticky status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            svc_addr_r  <= {ADDR_WIDTH{1'b0}};
            svc_data_r  <= {DATA_WIDTH{1'b0}};
            svc_read_r  <= 1'b0;
            svc_write_r <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= {DATA_WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (err_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        svc_addr_r  <= fifo_addr_r[rd_ptr_r];
                        svc_data_r  <= fifo_data_r[rd_ptr_r];
                        svc_read_r  <= fifo_read_r[rd_ptr_r];
                        svc_write_r <= fifo_write_r[rd_ptr_r];
                        cnt_r       <= CNT_W'(WAIT_STATES);
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        valid_r <= 1'b1;
                        if (rd_ok_s) begin
                            data_r <= sram_r[idx_s];
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_valid_o = valid_r;
    assign bus_data_o  = data_r;
    assign overflow_o  = overflow_r;
    assign err_o       = err_r;
    assign busy_o      = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_w0rm_dbus_sram_responder.sv
`timescale 1ns/1ps
// Directed bench for w0rm_dbus_sram_responder (WAIT_STATES=1, FIFO_DEPTH=4).
// Inputs change on falling edges; responses are logged on falling edges with
// their timestamp so latency and ordering can be checked against hand-derived
// times: a request driven at t0 answers at t0 + (3 + WAIT_STATES) * 10 when
// the block is idle, and later requests follow every (2 + WAIT_STATES) * 10.
module tb_w0rm_dbus_sram_responder;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] bus_addr_i = '0;
    logic [DW-1:0] bus_data_i = '0;
    logic          bus_read_i = 1'b0;
    logic          bus_write_i = 1'b0;
    logic          bus_valid_i = 1'b0;
    logic [DW-1:0] bus_data_o;
    logic          bus_valid_o;
    logic          overflow_o;
    logic          err_o;
    logic          busy_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        time         t;
        logic [31:0] d;
        logic        b;
    } resp_t;
    resp_t rq[$];

    w0rm_dbus_sram_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_WORDS  (1024),
        .WAIT_STATES(1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_addr_i (bus_addr_i),
        .bus_data_i (bus_data_i),
        .bus_read_i (bus_read_i),
        .bus_write_i(bus_write_i),
        .bus_valid_i(bus_valid_i),
        .bus_data_o (bus_data_o),
        .bus_valid_o(bus_valid_o),
        .overflow_o (overflow_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_valid_o === 1'b1) begin
            rq.push_back('{$time, bus_data_o, busy_o});
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        bus_addr_i  = a;
        bus_data_i  = d;
        bus_read_i  = rd;
        bus_write_i = wr;
        bus_valid_i = 1'b1;
    endtask

    task automatic idle_bus();
        bus_valid_i = 1'b0;
        bus_read_i  = 1'b0;
        bus_write_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(a, d, 1'b0, 1'b1);
        @(negedge clk);
        idle_bus();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus_valid_o); end
        total++; if (bus_data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus_data_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        time t0;
        rq.delete();
        @(negedge clk);
        t0 = $time;
        drive(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy_rise: got %0b want 1", busy_o); end
        drive(32'h10, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        idle_bus();
        repeat (12) @(negedge clk);
        total++;
        if (rq.size() != 2) begin bad++; $display("FAIL wr_count: got %0d want 2", rq.size()); end
        else begin
            total++; if (rq[0].t != t0 + 40 || rq[0].d !== 32'h0) begin bad++; $display("FAIL wr_ack: got t=%0t d=%h want t=%0t d=0", rq[0].t, rq[0].d, t0 + 40); end
            total++; if (rq[1].t != t0 + 70 || rq[1].d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_after_wr: got t=%0t d=%h want t=%0t d=deadbeef", rq[1].t, rq[1].d, t0 + 70); end
            total++; if (rq[0].b !== 1'b1 || rq[1].b !== 1'b0) begin bad++; $display("FAIL wr_busy_fall: got %0b%0b want 10", rq[0].b, rq[1].b); end
        end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL wr_err: got %0b want 0", err_o); end
    endtask

    task automatic test_burst();
        time t0;
        for (int k = 0; k < 8; k++) begin
            do_write(32'(k * 4), 32'h100 + 32'(k));
        end
        rq.delete();
        @(negedge clk);
        t0 = $time;
        for (int k = 0; k < 4; k++) begin
            drive(32'(k * 4), 32'h0, 1'b1, 1'b0);
            @(negedge clk);
        end
        idle_bus();
        repeat (16) @(negedge clk);
        total++;
        if (rq.size() != 4) begin bad++; $display("FAIL burst_count: got %0d want 4", rq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rq[i].t != t0 + 40 + 30 * i || rq[i].d !== 32'h100 + 32'(i)) begin
                    bad++;
                    $display("FAIL burst_resp%0d: got t=%0t d=%h want t=%0t d=%h", i, rq[i].t, rq[i].d, t0 + 40 + 30 * i, 32'h100 + 32'(i));
                end
            end
        end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL burst_overflow: got %0b want 0", overflow_o); end
    endtask

    task automatic test_overflow();
        time t0;
        logic [31:0] exp_d [7];
        for (int i = 0; i < 6; i++) exp_d[i] = 32'h100 + 32'(i);
        exp_d[6] = 32'h107;
        rq.delete();
        @(negedge clk);
        t0 = $time;
        for (int k = 0; k < 8; k++) begin
            drive(32'(k * 4), 32'h0, 1'b1, 1'b0);
            @(negedge clk);
        end
        idle_bus();
        repeat (24) @(negedge clk);
        total++;
        if (rq.size() != 7) begin bad++; $display("FAIL ovf_count: got %0d want 7", rq.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                total++;
                if (rq[i].t != t0 + 40 + 30 * i || rq[i].d !== exp_d[i]) begin
                    bad++;
                    $display("FAIL ovf_resp%0d: got t=%0t d=%h want t=%0t d=%h", i, rq[i].t, rq[i].d, t0 + 40 + 30 * i, exp_d[i]);
                end
            end
        end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow_o); end
    endtask

    task automatic test_addr_wrap();
        time t0;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ee;
`ifdef W0RM_DBUS_ADDR_CHECK_EN
        e0 = 32'h0; e1 = 32'h0; ee = 1'b1;
`else
        e0 = 32'h100; e1 = 32'h104; ee = 1'b0;
`endif
        rq.delete();
        @(negedge clk);
        t0 = $time;
        drive(32'h1002, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(32'h13, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        idle_bus();
        repeat (10) @(negedge clk);
        total++;
        if (rq.size() != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", rq.size()); end
        else begin
            total++; if (rq[0].t != t0 + 40 || rq[0].d !== e0) begin bad++; $display("FAIL wrap_1002: got t=%0t d=%h want t=%0t d=%h", rq[0].t, rq[0].d, t0 + 40, e0); end
            total++; if (rq[1].t != t0 + 70 || rq[1].d !== e1) begin bad++; $display("FAIL wrap_misalign: got t=%0t d=%h want t=%0t d=%h", rq[1].t, rq[1].d, t0 + 70, e1); end
        end
        total++; if (err_o !== ee) begin bad++; $display("FAIL wrap_err: got %0b want %0b", err_o, ee); end
    endtask

    task automatic test_bad_rw();
        time t0;
        do_write(32'h20, 32'hA5A50008);
        rq.delete();
        @(negedge clk);
        t0 = $time;
        drive(32'h20, 32'h00005555, 1'b1, 1'b1);
        @(negedge clk);
        drive(32'h20, 32'h00006666, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h20, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        idle_bus();
        repeat (12) @(negedge clk);
        total++;
        if (rq.size() != 3) begin bad++; $display("FAIL badrw_count: got %0d want 3", rq.size()); end
        else begin
            total++; if (rq[0].t != t0 + 40 || rq[0].d !== 32'h0) begin bad++; $display("FAIL badrw_both: got t=%0t d=%h want t=%0t d=0", rq[0].t, rq[0].d, t0 + 40); end
            total++; if (rq[1].t != t0 + 70 || rq[1].d !== 32'h0) begin bad++; $display("FAIL badrw_none: got t=%0t d=%h want t=%0t d=0", rq[1].t, rq[1].d, t0 + 70); end
            total++; if (rq[2].t != t0 + 100 || rq[2].d !== 32'hA5A50008) begin bad++; $display("FAIL badrw_keep: got t=%0t d=%h want t=%0t d=a5a50008", rq[2].t, rq[2].d, t0 + 100); end
        end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL badrw_err: got %0b want 1", err_o); end
    endtask

    task automatic test_reset_abort();
        time t0;
        rq.delete();
        @(negedge clk);
        t0 = $time;
        drive(32'h10, 32'h12345678, 1'b0, 1'b1);
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++; if (bus_valid_o !== 1'b0 || bus_data_o !== 32'h0) begin bad++; $display("FAIL abort_out: got v=%0b d=%h want v=0 d=0", bus_valid_o, bus_data_o); end
        total++; if (overflow_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL abort_flags: got ovf=%0b err=%0b want 0 0", overflow_o, err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy_o); end
        repeat (6) @(negedge clk);
        total++; if (rq.size() != 0) begin bad++; $display("FAIL abort_no_resp: got %0d want 0", rq.size()); end
        rq.delete();
        @(negedge clk);
        t0 = $time;
        drive(32'h10, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        idle_bus();
        repeat (8) @(negedge clk);
        total++;
        if (rq.size() != 1) begin bad++; $display("FAIL abort_readback_count: got %0d want 1", rq.size()); end
        else begin
            total++; if (rq[0].t != t0 + 40 || rq[0].d !== 32'h104) begin bad++; $display("FAIL abort_readback: got t=%0t d=%h want t=%0t d=104", rq[0].t, rq[0].d, t0 + 40); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_overflow();
        test_addr_wrap();
        test_bad_rw();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w0rm_dbus_sram_responder.md
# w0rm_dbus_sram_responder

Data-bus responder for the W0RM core: the slave end of the core's data port (`mem_addr_o`/`mem_data_o`/`mem_read_o`/`mem_write_o`/`mem_valid_o` in, `mem_data_i`/`mem_valid_i` out). It queues every request in a small FIFO, applies a programmable number of wait states, performs a word access on an internal synchronous SRAM, and returns exactly one single-cycle `bus_valid_o` pulse per request. The data port has no back-pressure signal, so the FIFO absorbs bursts and records overflow.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: byte-address width.
- `MEM_WORDS`, 1024: SRAM depth in words. Must be a power of 2.
- `WAIT_STATES`, 1: extra cycles per access, range 0–15.
- `FIFO_DEPTH`, 4: request queue depth. Must be a power of 2, at least 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`, input, 1: core clock.
  - `reset`, input, 1: synchronous, active-low.
- Request side (driven by the core):
  - `bus_addr_i`, input, ADDR_WIDTH: byte address.
  - `bus_data_i`, input, DATA_WIDTH: write data.
  - `bus_read_i`, input, 1: read request.
  - `bus_write_i`, input, 1: write request.
  - `bus_valid_i`, input, 1: request strobe, sampled on every `clk` edge.
- Response side (to the core):
  - `bus_data_o`, output, DATA_WIDTH: read data. 0 for writes and errors.
  - `bus_valid_o`, output, 1: response strobe, exactly one cycle per accepted request.
- Status:
  - `overflow_o`, output, 1: sticky; a request was dropped.
  - `err_o`, output, 1: sticky; a bad request was serviced (see Configuration).
  - `busy_o`, output, 1: FIFO not empty or FSM not in IDLE.

## Operation
- Reset (`reset`=0 at an edge): FIFO pointers and count cleared, FSM to IDLE, wait counter 0. All outputs go to 0. SRAM contents are retained. Reset asserted mid-access aborts that access: no write is performed and no response is issued.
- Push: on each edge with `bus_valid_i`=1, the tuple {addr, data, read, write} is written to the FIFO.
  - Full with no simultaneous pop: the request is dropped and `overflow_o` is set to 1 until reset.
  - Full with a simultaneous pop: the request is accepted.
- Word index is `bus_addr_i[log2(MEM_WORDS)+1:2]`.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head into the service register, load `cnt`=WAIT_STATES, and go to WAIT.
  - WAIT: if `cnt`≠0, decrement `cnt`. If `cnt`=0, perform the access, register the response, drive `bus_valid_o`=1 for the following cycle, and go to IDLE.
- Access decode:
  - read only: `bus_data_o` = SRAM[index].
  - write only: SRAM[index] ← data and `bus_data_o` = 0.
  - read and write both high, or both low: no SRAM change, `bus_data_o` = 0, `err_o` set. This happens even without the macro.
- `bus_valid_o` and `bus_data_o` are registered. `bus_data_o` returns to 0 when `bus_valid_o` deasserts.
- Ordering: responses are returned strictly in request order. A read issued after a write to the same address returns the new data.

## Timing
- Request sampled at edge N with an idle, empty block: pop at edge N+1, access at edge N+2+WAIT_STATES, `bus_valid_o` high for the single cycle following that edge.
- Service interval is WAIT_STATES+2 cycles per request. Requests arriving faster than this accumulate in the FIFO.
- With WAIT_STATES=0: request at edge 0 → response in the cycle after edge 2. Back-to-back responses appear every 2 cycles.
- `busy_o` rises in the cycle after the first push. It falls in the cycle in which `bus_valid_o` is high for the last queued request.

## Configuration
- `W0RM_DBUS_ADDR_CHECK_EN` defined:
  - An address with `addr[1:0]`≠0, or with word index ≥ MEM_WORDS (upper address bits nonzero), is treated as an error.
  - The error is still acknowledged: `bus_valid_o`=1, `bus_data_o`=0, no SRAM write, and `err_o` set sticky.
- `W0RM_DBUS_ADDR_CHECK_EN` undefined:
  - The low two bits and the upper bits are ignored, and the address wraps modulo MEM_WORDS.
  - `err_o` reports only the read/write-encoding error.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 (WAIT_STATES=1) → write ack at request+3 with data 0. Read response at its request+3 returns 0xDEADBEEF.
- 4 back-to-back reads of 0x0/0x4/0x8/0xC, preloaded with 1–4 (FIFO_DEPTH=4, WAIT_STATES=0) → 4 pulses, spaced 2 cycles apart, data 1,2,3,4 in order, no overflow.
- 6 back-to-back requests with FIFO_DEPTH=4, WAIT_STATES=3 → exactly the requests that fit are serviced, `overflow_o`=1, and the number of responses equals the number of accepted pushes.
- Read 0x1002 with the macro on (MEM_WORDS=1024) → one pulse, data 0, `err_o`=1. With the macro off → returns SRAM[0x400 mod 1024 = 0], `err_o`=0.
- Request with read and write both high → pulse, data 0, `err_o`=1, target word unchanged.
- Reset low in the cycle before a queued write completes → no `bus_valid_o`, SRAM word unchanged, all outputs 0, `busy_o`=0 after release.
